// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product stream in, finished-sum stream out
// Upstream/downstream handshake bundle for the product accumulator.
interface product_accumulator_if;
  logic [31:0] prod;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] acc_out;
  logic [7:0]  count_out;
  logic        ovf;

  modport master (
    output prod, in_valid, in_last, clear, out_ready,
    input  in_ready, out_valid, acc_out, count_out, ovf
  );

  modport slave (
    input  prod, in_valid, in_last, clear, out_ready,
    output in_ready, out_valid, acc_out, count_out, ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - saturating 40-bit sum of 32-bit products
// Sums products until in_last, then holds the result until out_ready.
module product_accumulator (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t      state;
  logic [39:0] acc;
  logic [7:0]  count;
  logic        ovf_q;
  logic        valid_q;
  logic        ready_q;

  logic        accept;
  logic [40:0] sum;
  logic [7:0]  count_inc;

  assign accept    = bus.in_valid & ready_q;
  assign sum       = {1'b0, acc} + {9'd0, bus.prod};
  assign count_inc = (count == 8'hFF) ? 8'hFF : count + 8'd1;

  assign bus.in_ready  = ready_q;
  assign bus.out_valid = valid_q;
  assign bus.acc_out   = acc;
  assign bus.count_out = count;
  assign bus.ovf       = ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= 40'd0;
      count   <= 8'd0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          // clear wins over a simultaneous accept; the product is dropped
          if (bus.clear) begin
            state   <= IDLE;
            acc     <= 40'd0;
            count   <= 8'd0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end else if (accept) begin
            if (state == IDLE) begin
              acc   <= {8'd0, bus.prod};
              count <= 8'd1;
              ovf_q <= 1'b0;
            end else begin
              if (sum[40]) begin
                acc   <= 40'hFF_FFFF_FFFF;
                ovf_q <= 1'b1;
              end else begin
                acc <= sum[39:0];
              end
              count <= count_inc;
            end
            if (bus.in_last) begin
              state   <= HOLD;
              valid_q <= 1'b1;
              ready_q <= 1'b0;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - scoreboard bench for product_accumulator
// Expected sums come from plain integer arithmetic over the accepted products.
module tb_product_accumulator;

  localparam longint unsigned SAT_MAX = 64'h0000_00FF_FFFF_FFFF;

  typedef struct {
    logic [39:0] acc;
    logic [7:0]  cnt;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  product_accumulator_if bus ();

  product_accumulator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t            exp_q[$];
  int              checks = 0;
  int              errors = 0;
  longint unsigned m_sum  = 0;
  int              m_n    = 0;
  bit              rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_sum = 0;
    m_n   = 0;
  endtask

  task automatic model_accept(input logic [31:0] p, input bit last);
    exp_t            e;
    longint unsigned s;
    m_sum += longint'(p);
    m_n++;
    if (last) begin
      s     = (m_sum > SAT_MAX) ? SAT_MAX : m_sum;
      e.acc = s[39:0];
      e.cnt = (m_n > 255) ? 8'd255 : 8'(m_n);
      e.ovf = (m_sum > SAT_MAX);
      exp_q.push_back(e);
      model_reset();
    end
  endtask

  // entered and left at posedge+1
  task automatic send(input logic [31:0] p, input bit last);
    bit done;
    bit r;
    done         = 1'b0;
    bus.prod     = p;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      if (r) begin
        model_accept(p, last);
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear(input bit with_valid);
    bus.clear    = 1'b1;
    bus.in_valid = with_valid;
    bus.prod     = $urandom;
    bus.in_last  = $urandom_range(0, 1);
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    model_reset();
  endtask

  function automatic logic [31:0] rand_prod();
    case ($urandom_range(0, 3))
      0:       return 32'd0;
      1:       return 32'hFFFE_0001;
      2:       return $urandom;
      default: return $urandom_range(0, 1000);
    endcase
  endfunction

  // monitor: every cycle the held result must match the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("in_ready_vs_out_valid", 64'(bus.in_ready), 64'(!bus.out_valid));
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 64'd1, 64'd0);
          end else begin
            check("acc_out", 64'(bus.acc_out), 64'(exp_q[0].acc));
            check("count_out", 64'(bus.count_out), 64'(exp_q[0].cnt));
            check("ovf", 64'(bus.ovf), 64'(exp_q[0].ovf));
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_rdy) bus.out_ready = $urandom_range(0, 1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.prod      = 32'd0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_acc", 64'(bus.acc_out), 64'd0);
    check("rst_count", 64'(bus.count_out), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    rst = 1'b0;
    idle(2);

    // three-term sum, one-cycle latency
    send(32'h0000_0001, 1'b0);
    send(32'h0000_0002, 1'b0);
    send(32'hFFFE_0001, 1'b1);
    check("latency_out_valid", 64'(bus.out_valid), 64'd1);
    check("three_term_acc", 64'(bus.acc_out), 64'h00_FFFE_0004);
    idle(3);

    // backpressure: result held, pending product refused
    bus.out_ready = 1'b0;
    send(32'h1234_5678, 1'b1);
    bus.prod     = 32'h11;
    bus.in_last  = 1'b1;
    bus.in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(32'h11, 1'b1);
    idle(3);

    // saturation of sum and count
    for (int i = 0; i < 300; i++) send(32'hFFFE_0001, 1'b0);
    send(32'hFFFE_0001, 1'b1);
    idle(3);

    // clear discards the partial sum and the simultaneous product
    send(32'd5, 1'b0);
    send(32'd7, 1'b0);
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.prod     = 32'd9;
    bus.in_last  = 1'b0;
    @(negedge clk);
    check("clear_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    check("clear_acc", 64'(bus.acc_out), 64'd0);
    check("clear_count", 64'(bus.count_out), 64'd0);
    send(32'd3, 1'b1);
    idle(3);

    // clear is ignored while a result is held
    bus.out_ready = 1'b0;
    send(32'h55, 1'b1);
    bus.clear = 1'b1;
    idle(3);
    bus.clear     = 1'b0;
    bus.out_ready = 1'b1;
    idle(3);

    // asynchronous reset mid-sum
    send(32'h80, 1'b0);
    send(32'h80, 1'b0);
    @(negedge clk);
    check("pre_rst_acc", 64'(bus.acc_out), 64'h100);
    check("pre_rst_count", 64'(bus.count_out), 64'd2);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_acc", 64'(bus.acc_out), 64'd0);
    check("async_rst_count", 64'(bus.count_out), 64'd0);
    check("async_rst_ovf", 64'(bus.ovf), 64'd0);
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    send(32'd4, 1'b1);
    idle(3);

    // randomized sums with random backpressure, gaps and aborts
    rand_rdy = 1'b1;
    for (int s = 0; s < 40; s++) begin
      int  n;
      bit  aborted;
      n       = $urandom_range(1, 6);
      aborted = 1'b0;
      for (int k = 0; k < n && !aborted; k++) begin
        send(rand_prod(), k == n - 1);
        if (k < n - 1 && $urandom_range(0, 7) == 0) begin
          pulse_clear($urandom_range(0, 1));
          aborted = 1'b1;
        end else if ($urandom_range(0, 3) == 0) begin
          idle($urandom_range(1, 3));
        end
      end
    end
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) idle(1);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL expose: prod  input  32  unsigned product from the upstream 16x16 array multiplier output c.
REQ-004 SHALL expose: in_valid  input  1  prod/in_last valid this cycle.
REQ-005 SHALL expose: in_last  input  1  marks final product of the current sum.
REQ-006 SHALL expose: in_ready  output  1  block accepts a product this cycle.
REQ-007 SHALL expose: clear  input  1  synchronous abort of the current sum.
REQ-008 SHALL expose: out_valid  output  1  acc_out/count_out/ovf hold a finished sum.
REQ-009 SHALL expose: out_ready  input  1  downstream accepts the result.
REQ-010 SHALL expose: acc_out  output  40  accumulated sum.
REQ-011 SHALL expose: count_out  output  8  number of products in the sum.
REQ-012 SHALL expose: ovf  output  1  sticky saturation flag for the current sum.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, HOLD; IDLE after reset.
REQ-014 SHALL define accept = in_valid & in_ready; in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-015 SHALL, on accept in IDLE, load acc = zero-extended prod, count = 1, ovf = 0 (no carry-in of old values).
REQ-016 SHALL, on accept in ACCUM, compute acc + zero-extended prod in 41 bits; if bit 40 set, acc = 40'hFF_FFFF_FFFF and ovf = 1, else acc = 40-bit sum.
REQ-017 SHALL saturate count at 255; further accepts leave it at 255.
REQ-018 SHALL transition on accept: in_last = 0 -> ACCUM; in_last = 1 -> HOLD.
REQ-019 SHALL assert out_valid exactly in HOLD; latency from accept of in_last to out_valid = 1 cycle, result including that product.
REQ-020 SHALL hold acc_out, count_out, ovf stable while out_valid = 1 and out_ready = 0.
REQ-021 SHALL transition HOLD -> IDLE on out_ready = 1; outputs retain last values in IDLE until the next accept.
REQ-022 SHALL, in IDLE or ACCUM with clear = 1, zero acc, count, ovf and go to IDLE; clear overrides a simultaneous accept (product discarded, in_ready still 1).
REQ-023 SHALL ignore clear in HOLD; result delivered unchanged.
REQ-024 SHALL ignore prod/in_last when in_valid = 0; no state change.
REQ-025 SHALL treat prod = 0 as a valid term (count increments).
REQ-026 SHALL produce no output for an idle period of any length.

Reset
REQ-027 SHALL, on rst = 1 at any time including mid-sum or in HOLD, immediately force state IDLE, acc_out = 0, count_out = 0, ovf = 0, out_valid = 0, in_ready = 1 without waiting for clk.
REQ-028 SHALL discard any partial sum on reset; first accept after rst release starts a new sum per REQ-015.

Verification
REQ-029 Three-term sum: prods 0x0000_0001, 0x0000_0002, 0xFFFE_0001 (=0xFFFF*0xFFFF), last on third, out_ready=1 -> next cycle out_valid=1, acc_out=0x00_FFFE_0004, count_out=3, ovf=0.
REQ-030 Backpressure: single prod 0x1234_5678 with in_last, out_ready=0 for 5 cycles -> out_valid=1 and in_ready=0 throughout, acc_out=0x00_1234_5678 stable; in_valid held high is not accepted; out_ready=1 -> IDLE next cycle, then held product accepted.
REQ-031 Saturation: 300 accepts of 0xFFFE_0001 then last -> acc_out=0xFF_FFFF_FFFF, ovf=1, count_out=255.
REQ-032 Clear: two prods 5, 7, then clear with in_valid=1 prod=9 -> no accept; then prod 3 with last -> acc_out=3, count_out=1.
REQ-033 Async reset: assert rst mid-cycle during ACCUM with acc=0x100 -> outputs zero before next clk edge; after release, prod 4 with last -> acc_out=4, count_out=1.
